// File: rtl/mem_sp_arbiter_if.sv
// Request/response channel between one requester and the single-port RAM arbiter.
// The requester drives the master side and the arbiter drives the slave side.
interface mem_sp_arbiter_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 64,
    parameter int DATA_BYTES = DATA_WIDTH / 8
);
    logic                  valid;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_BYTES-1:0] wen;
    logic                  ready;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_ready;

    modport master (
        output valid, addr, wdata, wen, rsp_ready,
        input  ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  valid, addr, wdata, wen, rsp_ready,
        output ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/mem_sp_arbiter.sv
// Two-port round-robin arbiter sharing one write-first single-port RAM, one access per cycle.
// Each port owns a one-word hold register so a stalled response never blocks the other port.
module mem_sp_arbiter #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 64,
    parameter int DATA_BYTES = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_sp_arbiter_if.slave       p0,
    mem_sp_arbiter_if.slave       p1,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [DATA_BYTES-1:0] mem_wen,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INFLT = 2'd1,
        ST_HELD  = 2'd2
    } port_state_t;

    logic [1:0]            req_valid;
    logic [1:0]            req_rsp_ready;
    logic [ADDR_WIDTH-1:0] req_addr  [2];
    logic [DATA_WIDTH-1:0] req_wdata [2];
    logic [DATA_BYTES-1:0] req_wen   [2];

    logic [1:0]            eligible;
    logic [1:0]            grant;
    logic [1:0]            rsp_valid_vec;
    logic [DATA_WIDTH-1:0] rsp_rdata_vec [2];

    logic                  last_grant_reg;
    logic                  last_grant_next;

    assign req_valid     = {p1.valid, p0.valid};
    assign req_rsp_ready = {p1.rsp_ready, p0.rsp_ready};
    assign req_addr[0]   = p0.addr;
    assign req_addr[1]   = p1.addr;
    assign req_wdata[0]  = p0.wdata;
    assign req_wdata[1]  = p1.wdata;
    assign req_wen[0]    = p0.wen;
    assign req_wen[1]    = p1.wen;

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        port_state_t           state_reg;
        port_state_t           state_next;
        logic [DATA_WIDTH-1:0] hold_reg;
        logic [DATA_WIDTH-1:0] hold_next;

        // A held word must drain before this port may reuse the shared read bus.
        assign eligible[gi] = req_valid[gi] &
                              ((state_reg == ST_IDLE) |
                               ((state_reg == ST_INFLT) & req_rsp_ready[gi]));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_reg <= ST_IDLE;
                hold_reg  <= '0;
            end else begin
                state_reg <= state_next;
                hold_reg  <= hold_next;
            end
        end

        always_comb begin
            state_next = state_reg;
            hold_next  = hold_reg;
            case (state_reg)
                ST_IDLE: begin
                    if (grant[gi]) begin
                        state_next = ST_INFLT;
                    end
                end
                ST_INFLT: begin
                    if (!req_rsp_ready[gi]) begin
                        state_next = ST_HELD;
                        hold_next  = mem_rdata;
                    end else if (!grant[gi]) begin
                        state_next = ST_IDLE;
                    end
                end
                ST_HELD: begin
                    if (req_rsp_ready[gi]) begin
                        state_next = ST_IDLE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end

        assign rsp_valid_vec[gi] = (state_reg != ST_IDLE);
        assign rsp_rdata_vec[gi] = (state_reg == ST_HELD) ? hold_reg : mem_rdata;
    end

    // Reset masks the grant so no write can reach the RAM while rst is high.
    always_comb begin
        grant = eligible;
        if (rst) begin
            grant = '0;
        end else if (eligible == 2'b11) begin
            grant = last_grant_reg ? 2'b01 : 2'b10;
        end
    end

    assign last_grant_next = (|grant) ? grant[1] : last_grant_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_reg <= 1'b1;
        end else begin
            last_grant_reg <= last_grant_next;
        end
    end

    always_comb begin
        mem_addr  = req_addr[0];
        mem_wdata = req_wdata[0];
        mem_wen   = '0;
        if (grant[1]) begin
            mem_addr  = req_addr[1];
            mem_wdata = req_wdata[1];
            mem_wen   = req_wen[1];
        end else if (grant[0]) begin
            mem_wen   = req_wen[0];
        end
    end

    assign p0.ready     = grant[0];
    assign p1.ready     = grant[1];
    assign p0.rsp_valid = rsp_valid_vec[0];
    assign p1.rsp_valid = rsp_valid_vec[1];
    assign p0.rsp_rdata = rsp_rdata_vec[0];
    assign p1.rsp_rdata = rsp_rdata_vec[1];

endmodule

// File: tb/tb_mem_sp_arbiter.sv
// Randomized scoreboard bench for mem_sp_arbiter with a write-first RAM model behind it.
// The reference is a flat word array plus per-port queues of expected responses.
module tb_mem_sp_arbiter;
    localparam int AW = 11;
    localparam int DW = 64;
    localparam int DB = DW / 8;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DB-1:0] wen;
    } req_t;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mem_sp_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DATA_BYTES(DB)) p0_if ();
    mem_sp_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DATA_BYTES(DB)) p1_if ();

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DB-1:0] mem_wen;
    logic [DW-1:0] mem_rdata;

    mem_sp_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DATA_BYTES(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .p0        (p0_if),
        .p1        (p1_if),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wen   (mem_wen),
        .mem_rdata (mem_rdata)
    );

    // Requester side
    logic drv_valid     [2];
    logic drv_rsp_ready [2];
    req_t cur           [2];
    logic req_pend      [2];
    logic          dut_ready     [2];
    logic          dut_rsp_valid [2];
    logic [DW-1:0] dut_rdata     [2];

    assign p0_if.valid     = drv_valid[0];
    assign p0_if.addr      = cur[0].addr;
    assign p0_if.wdata     = cur[0].wdata;
    assign p0_if.wen       = cur[0].wen;
    assign p0_if.rsp_ready = drv_rsp_ready[0];
    assign p1_if.valid     = drv_valid[1];
    assign p1_if.addr      = cur[1].addr;
    assign p1_if.wdata     = cur[1].wdata;
    assign p1_if.wen       = cur[1].wen;
    assign p1_if.rsp_ready = drv_rsp_ready[1];
    assign dut_ready[0]     = p0_if.ready;
    assign dut_ready[1]     = p1_if.ready;
    assign dut_rsp_valid[0] = p0_if.rsp_valid;
    assign dut_rsp_valid[1] = p1_if.rsp_valid;
    assign dut_rdata[0]     = p0_if.rsp_rdata;
    assign dut_rdata[1]     = p1_if.rsp_rdata;

    // RAM model: write-first, registered read, preloadable while the arbiter is in reset
    logic [DW-1:0] ram [2**AW];
    logic [DW-1:0] ram_rdata;
    logic          preload_we = 1'b0;
    logic [AW-1:0] preload_addr = '0;
    logic [DW-1:0] preload_data = '0;
    assign mem_rdata = ram_rdata;

    function automatic logic [DW-1:0] ram_merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                                input logic [DB-1:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < DB; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (preload_we) ram[preload_addr] <= preload_data;
        else            ram[mem_addr]     <= ram_merge(ram[mem_addr], mem_wdata, mem_wen);
        ram_rdata <= ram_merge(ram[mem_addr], mem_wdata, mem_wen);
    end

    // Reference model and scoreboard
    logic [DW-1:0] ref_mem [2**AW];
    exp_t exp_q   [2][$];
    req_t force_q [2][$];
    int   grant_cnt [2];
    int   req_rate [2];
    int   rsp_rate [2];
    int   wr_rate = 0;
    int   addr_max = 15;
    logic last_win = 1'b1;
    int   checks = 0;
    int   passes = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic ref_access(input req_t r, output logic [DW-1:0] word);
        logic [DW-1:0] mask;
        mask = '0;
        for (int b = 0; b < DB; b++) if (r.wen[b]) mask[b*8 +: 8] = 8'hFF;
        ref_mem[r.addr] = (ref_mem[r.addr] & ~mask) | (r.wdata & mask);
        word = ref_mem[r.addr];
    endtask

    function automatic req_t rand_req();
        req_t r;
        r.addr  = AW'($urandom_range(addr_max));
        r.wdata = {$urandom, $urandom};
        r.wen   = (int'($urandom_range(99)) < wr_rate) ? DB'($urandom) : '0;
        return r;
    endfunction

    function automatic req_t mk_req(input int a, input logic [DW-1:0] wd, input logic [DB-1:0] be);
        req_t r;
        r.addr  = AW'(a);
        r.wdata = wd;
        r.wen   = be;
        return r;
    endfunction

    task automatic step_drive();
        for (int p = 0; p < 2; p++) begin
            if (!req_pend[p]) begin
                if (force_q[p].size() > 0) begin
                    cur[p] = force_q[p].pop_front();
                    req_pend[p] = 1'b1;
                end else if (int'($urandom_range(99)) < req_rate[p]) begin
                    cur[p] = rand_req();
                    req_pend[p] = 1'b1;
                end
            end
            drv_valid[p]     = req_pend[p];
            drv_rsp_ready[p] = (int'($urandom_range(99)) < rsp_rate[p]);
        end
    endtask

    // A transfer happens this cycle: queue the response the RAM contents say it must return.
    task automatic step_collect();
        for (int p = 0; p < 2; p++) begin
            if (req_pend[p] && dut_ready[p]) begin
                exp_t e;
                ref_access(cur[p], e.data);
                e.cyc = cyc;
                exp_q[p].push_back(e);
                req_pend[p] = 1'b0;
                grant_cnt[p]++;
            end
        end
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            step_drive();
            #3;
            step_collect();
        end
    endtask

    task automatic set_rates(input int r0, input int r1, input int s0, input int s1);
        req_rate[0] = r0;
        req_rate[1] = r1;
        rsp_rate[0] = s0;
        rsp_rate[1] = s1;
    endtask

    // Monitor: predicts grants from who is waiting and how old each owed response is.
    initial begin
        forever begin
            @(negedge clk);
            begin : mon_cycle
                logic       older [2];
                logic [1:0] elig;
                logic [1:0] g_exp;
                int         s;
                for (int p = 0; p < 2; p++) begin
                    older[p] = (exp_q[p].size() > 0) && (exp_q[p][0].cyc < cyc);
                    elig[p]  = !rst && drv_valid[p] &&
                               (!older[p] || ((exp_q[p][0].cyc == cyc - 1) && drv_rsp_ready[p]));
                end
                g_exp = (elig == 2'b11) ? (last_win ? 2'b01 : 2'b10) : elig;
                for (int p = 0; p < 2; p++) begin
                    check($sformatf("p%0d ready", p), 64'(dut_ready[p]), 64'(g_exp[p]));
                    check($sformatf("p%0d rsp_valid", p), 64'(dut_rsp_valid[p]), 64'(older[p]));
                    if (older[p] && drv_rsp_ready[p]) begin
                        exp_t e;
                        e = exp_q[p].pop_front();
                        check($sformatf("p%0d rsp_rdata", p), dut_rdata[p], e.data);
                        $display("p%0d response %h (issued cycle %0d, consumed cycle %0d)",
                                 p, dut_rdata[p], e.cyc, cyc);
                    end
                end
                if (g_exp != 2'b00) begin
                    s = g_exp[1] ? 1 : 0;
                    check("mem_addr", 64'(mem_addr), 64'(cur[s].addr));
                    check("mem_wen", 64'(mem_wen), 64'(cur[s].wen));
                    if (cur[s].wen != '0) check("mem_wdata", mem_wdata, cur[s].wdata);
                    last_win = g_exp[1];
                end else begin
                    check("mem_wen idle", 64'(mem_wen), 64'd0);
                end
            end
        end
    end

    initial begin
        int c0;
        int c1;
        logic [DW-1:0] w;
        for (int p = 0; p < 2; p++) begin
            grant_cnt[p] = 0;
            req_pend[p]  = 1'b1;
            drv_valid[p] = 1'b1;
            drv_rsp_ready[p] = 1'b1;
        end
        set_rates(0, 0, 100, 100);
        cur[0] = mk_req(5, '0, '0);
        cur[1] = mk_req(7, '0, '0);

        // Reset held with both ports requesting while the RAM is preloaded.
        for (int i = 0; i < 32; i++) begin
            @(posedge clk);
            #1;
            w = {$urandom, $urandom};
            if (i == 5) w = 64'h0123456789ABCDEF;
            if (i == 3) w = '0;
            preload_we   = 1'b1;
            preload_addr = AW'(i);
            preload_data = w;
            ref_mem[i]   = w;
        end
        @(posedge clk);
        #1;
        preload_we = 1'b0;
        check("rst p0 ready", 64'(dut_ready[0]), 64'd0);
        check("rst p1 ready", 64'(dut_ready[1]), 64'd0);
        check("rst p0 rsp_valid", 64'(dut_rsp_valid[0]), 64'd0);
        check("rst mem_wen", 64'(mem_wen), 64'd0);

        // Release: p0 wins the first tie and reads the preloaded word at addr 5.
        rst = 1'b0;
        #3;
        step_collect();
        check("first grant p0", 64'(grant_cnt[0]), 64'd1);
        check("first grant p1", 64'(grant_cnt[1]), 64'd0);
        run_cycles(4);

        // Contention: reads on both ports every cycle must alternate.
        c0 = grant_cnt[0];
        c1 = grant_cnt[1];
        set_rates(100, 100, 100, 100);
        wr_rate = 0;
        run_cycles(8);
        check("alternate p0 grants", 64'(grant_cnt[0] - c0), 64'd4);
        check("alternate p1 grants", 64'(grant_cnt[1] - c1), 64'd4);
        set_rates(0, 0, 100, 100);
        run_cycles(4);

        // Partial byte write on p1, then read back on p0.
        force_q[1].push_back(mk_req(3, 64'h00000000FFFFFFFF, 8'h0F));
        run_cycles(3);
        force_q[0].push_back(mk_req(3, '0, '0));
        run_cycles(3);

        // p0 stalls its response while p1 streams; p0 must stay excluded until drained.
        force_q[0].push_back(mk_req(5, '0, '0));
        force_q[0].push_back(mk_req(6, '0, '0));
        set_rates(0, 100, 0, 100);
        run_cycles(5);
        rsp_rate[0] = 100;
        run_cycles(4);
        set_rates(0, 0, 100, 100);
        run_cycles(4);

        // Randomized traffic with frequent address collisions and partial writes.
        wr_rate = 50;
        for (int blk = 0; blk < 12; blk++) begin
            set_rates($urandom_range(100), $urandom_range(100),
                      $urandom_range(20, 100), $urandom_range(20, 100));
            run_cycles(50);
        end
        set_rates(0, 0, 100, 100);
        run_cycles(5);

        // Asynchronous reset between edges while p1 has a read in flight.
        force_q[1].push_back(mk_req(9, '0, '0));
        run_cycles(1);
        @(posedge clk);
        #1;
        step_drive();
        check("p1 rsp_valid before rst", 64'(dut_rsp_valid[1]), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        check("async rst p1 rsp_valid", 64'(dut_rsp_valid[1]), 64'd0);
        check("async rst mem_wen", 64'(mem_wen), 64'd0);
        exp_q[0].delete();
        exp_q[1].delete();
        last_win = 1'b1;
        rst = 1'b0;
        #1;
        step_collect();
        c0 = grant_cnt[0];
        c1 = grant_cnt[1];
        force_q[0].push_back(mk_req(1, '0, '0));
        force_q[1].push_back(mk_req(2, '0, '0));
        run_cycles(1);
        check("post-rst tie p0", 64'(grant_cnt[0] - c0), 64'd1);
        check("post-rst tie p1", 64'(grant_cnt[1] - c1), 64'd0);
        run_cycles(5);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
